apb_protocol_checker: RTL and testbench

- Synthesizable, passive APB protocol checker that taps a multi-slave APB bus (one-hot PSEL vector).
- Tracks each transfer through an IDLE/SETUP/ACCESS state machine.
- Flags protocol violations as sticky status bits and raises a maskable interrupt.
- Counts completed transfers, wait-state hangs and error events; usable in silicon debug and as a bus-side bench monitor.

---
 rtl/apb_chk_pkg.sv | 24 ++
 rtl/apb_chk_sat_counter.sv | 27 ++
 rtl/apb_protocol_checker.sv | 170 +++++++++++++++++
 tb/tb_apb_protocol_checker.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_chk_pkg.sv
// Shared types and constants for the APB protocol checker.
// Optional write-address map enabled by defining APB_CHK_ADDR_MAP_EN.
package apb_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int ERR_PEN_NO_SETUP    = 0;
  localparam int ERR_SETUP_NO_ACCESS = 1;
  localparam int ERR_UNSTABLE        = 2;
  localparam int ERR_PSEL_MULTI      = 3;
  localparam int ERR_HANG            = 4;
  localparam int ERR_ADDR_MAP        = 5;
  localparam int ERR_W               = 6;

`ifdef APB_CHK_ADDR_MAP_EN
  localparam int NUM_LEGAL_WR = 3;
  localparam logic [31:0] LEGAL_WR_ADDR [NUM_LEGAL_WR] = '{32'h0000_0000, 32'h0000_00F0, 32'h0000_00F4};
`endif

endpackage

// File: rtl/apb_chk_sat_counter.sv
// Event counter that either saturates at all-ones or wraps, chosen by SATURATE.
module apb_chk_sat_counter #(
  parameter int CNT_WIDTH = 16,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_inc,
  output logic [CNT_WIDTH-1:0] o_cnt
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_hold;

  assign w_hold = SATURATE && (&r_cnt);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_inc && !w_hold)
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/apb_protocol_checker.sv
// Passive APB bus monitor: tracks IDLE/SETUP/ACCESS, flags violations, counts transfers.
// Define APB_CHK_ADDR_MAP_EN to check write addresses against the legal map (err_flags[5]).
module apb_protocol_checker
  import apb_chk_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int HANG_THRESHOLD = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  preset,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  input  logic [NUM_SLAVES-1:0] psel,
  input  logic                  penable,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic                  chk_en,
  input  logic                  err_clr,
  input  logic [ERR_W-1:0]      err_mask,
  output logic [ERR_W-1:0]      err_flags,
  output logic                  err_irq,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [CNT_WIDTH-1:0]  xfer_cnt,
  output logic [CNT_WIDTH-1:0]  slverr_cnt,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  localparam int WAIT_W = $clog2(HANG_THRESHOLD + 1);

  apb_state_e            r_state, w_state_nxt;
  logic [WAIT_W-1:0]     r_wait_cnt, w_wait_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [NUM_SLAVES-1:0] r_sel;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [ERR_W-1:0]      r_flags;
  logic                  r_irq;
  logic [ADDR_WIDTH-1:0] r_err_addr;

  logic             w_sel_any, w_unstable, w_latch, w_complete;
  logic [ERR_W-1:0] w_viol;
  logic             w_err_inc, w_xfer_inc, w_slverr_inc;

  assign w_sel_any  = |psel;
  assign w_unstable = (paddr != r_addr) || (pwrite != r_write) || (psel != r_sel) ||
                      (r_write && (pwdata != r_wdata));

`ifdef APB_CHK_ADDR_MAP_EN
  logic w_addr_bad;
  always_comb begin
    w_addr_bad = 1'b1;
    for (int i = 0; i < NUM_LEGAL_WR; i++)
      if (paddr == ADDR_WIDTH'(LEGAL_WR_ADDR[i])) w_addr_bad = 1'b0;
  end
`endif

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_latch     = 1'b0;
    w_complete  = 1'b0;
    w_viol      = '0;
    w_viol[ERR_PSEL_MULTI] = ($countones(psel) > 1);
    unique case (r_state)
      IDLE: begin
        w_wait_nxt = '0;
        if (w_sel_any) begin
          w_latch = 1'b1;
`ifdef APB_CHK_ADDR_MAP_EN
          w_viol[ERR_ADDR_MAP] = pwrite && w_addr_bad;
`endif
          if (penable) begin
            w_viol[ERR_PEN_NO_SETUP] = 1'b1;
            w_state_nxt = ACCESS;
            w_wait_nxt  = WAIT_W'(1);
          end else begin
            w_state_nxt = SETUP;
          end
        end
      end
      SETUP: begin
        if (!penable) begin
          w_viol[ERR_SETUP_NO_ACCESS] = 1'b1;
          w_latch     = 1'b1;
          w_state_nxt = w_sel_any ? SETUP : IDLE;
        end else begin
          w_viol[ERR_UNSTABLE] = w_unstable;
          if (pready) begin
            w_complete  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = ACCESS;
            w_wait_nxt  = WAIT_W'(1);
          end
        end
      end
      ACCESS: begin
        w_viol[ERR_UNSTABLE] = w_unstable || !penable;
        if (pready) begin
          w_complete  = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_wait_cnt == WAIT_W'(HANG_THRESHOLD)) begin
          w_viol[ERR_HANG] = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_wait_nxt = r_wait_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_sel      <= '0;
      r_wdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_latch) begin
        r_addr  <= paddr;
        r_write <= pwrite;
        r_sel   <= psel;
        r_wdata <= pwdata;
      end
    end
  end

  // Clear and new violations in the same cycle: the new bits win.
  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      r_flags    <= '0;
      r_irq      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_irq <= |(r_flags & err_mask);
      if (chk_en) begin
        r_flags <= (err_clr ? '0 : r_flags) | w_viol;
        if (|w_viol) r_err_addr <= paddr;
      end
    end
  end

  assign w_err_inc    = chk_en && (|w_viol);
  assign w_xfer_inc   = chk_en && w_complete;
  assign w_slverr_inc = w_xfer_inc && pslverr;

  apb_chk_sat_counter #(.CNT_WIDTH(CNT_WIDTH), .SATURATE(1'b1)) u_err_cnt (
    .clk(clk), .rst(preset), .i_inc(w_err_inc), .o_cnt(err_cnt));

  apb_chk_sat_counter #(.CNT_WIDTH(CNT_WIDTH), .SATURATE(1'b0)) u_xfer_cnt (
    .clk(clk), .rst(preset), .i_inc(w_xfer_inc), .o_cnt(xfer_cnt));

  apb_chk_sat_counter #(.CNT_WIDTH(CNT_WIDTH), .SATURATE(1'b1)) u_slverr_cnt (
    .clk(clk), .rst(preset), .i_inc(w_slverr_inc), .o_cnt(slverr_cnt));

  assign err_flags = r_flags;
  assign err_irq   = r_irq;
  assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Directed bench for apb_protocol_checker; a 4-bit-counter copy on the same bus checks saturation and wrap.
module tb_apb_protocol_checker;

`ifdef APB_CHK_ADDR_MAP_EN
  localparam int AMAP = 1;
`else
  localparam int AMAP = 0;
`endif

  logic        clk = 1'b0;
  logic        preset;
  logic [15:0] paddr;
  logic        pwrite;
  logic [3:0]  psel;
  logic        penable;
  logic [31:0] pwdata;
  logic        pready;
  logic        pslverr;
  logic        chk_en;
  logic        err_clr;
  logic [5:0]  err_mask;

  logic [5:0]  err_flags, s_err_flags;
  logic        err_irq, s_err_irq;
  logic [15:0] err_cnt, xfer_cnt, slverr_cnt, err_addr, s_err_addr;
  logic [3:0]  s_err_cnt, s_xfer_cnt, s_slverr_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [5:0]  flags;
    logic [15:0] xfer;
    logic [15:0] errc;
    logic [15:0] slv;
  } snap_t;

  snap_t exp_q[$];

  always #5 clk = ~clk;

  apb_protocol_checker #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_SLAVES(4), .HANG_THRESHOLD(4), .CNT_WIDTH(16)
  ) u_dut (
    .clk(clk), .preset(preset), .paddr(paddr), .pwrite(pwrite), .psel(psel),
    .penable(penable), .pwdata(pwdata), .pready(pready), .pslverr(pslverr),
    .chk_en(chk_en), .err_clr(err_clr), .err_mask(err_mask),
    .err_flags(err_flags), .err_irq(err_irq), .err_cnt(err_cnt),
    .xfer_cnt(xfer_cnt), .slverr_cnt(slverr_cnt), .err_addr(err_addr)
  );

  apb_protocol_checker #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_SLAVES(4), .HANG_THRESHOLD(4), .CNT_WIDTH(4)
  ) u_dut_small (
    .clk(clk), .preset(preset), .paddr(paddr), .pwrite(pwrite), .psel(psel),
    .penable(penable), .pwdata(pwdata), .pready(pready), .pslverr(pslverr),
    .chk_en(chk_en), .err_clr(err_clr), .err_mask(err_mask),
    .err_flags(s_err_flags), .err_irq(s_err_irq), .err_cnt(s_err_cnt),
    .xfer_cnt(s_xfer_cnt), .slverr_cnt(s_slverr_cnt), .err_addr(s_err_addr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_snap(input string tag, input logic [5:0] flags, input logic [15:0] xfer,
                             input logic [15:0] errc, input logic [15:0] slv);
    snap_t s;
    s.tag = tag; s.flags = flags; s.xfer = xfer; s.errc = errc; s.slv = slv;
    exp_q.push_back(s);
  endtask

  task automatic check_snap();
    snap_t s;
    total++;
    assert (exp_q.size() != 0) else begin
      bad++;
      $error("FAIL scoreboard_empty: observed=%0d expected=>0", exp_q.size());
    end
    if (exp_q.size() != 0) begin
      s = exp_q.pop_front();
      check({s.tag, "_flags"},  64'(err_flags),  64'(s.flags));
      check({s.tag, "_xfer"},   64'(xfer_cnt),   64'(s.xfer));
      check({s.tag, "_errcnt"}, 64'(err_cnt),    64'(s.errc));
      check({s.tag, "_slverr"}, 64'(slverr_cnt), 64'(s.slv));
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_bus();
    psel = '0; penable = 1'b0; pready = 1'b0; pslverr = 1'b0;
  endtask

  task automatic apb_xfer(input logic [15:0] addr, input logic wr, input logic [3:0] sel,
                          input logic [31:0] data, input int waits, input logic slv);
    paddr = addr; pwrite = wr; psel = sel; pwdata = data;
    penable = 1'b0; pready = 1'b0; pslverr = 1'b0;
    step();
    penable = 1'b1;
    for (int i = 0; i < waits; i++) step();
    pready = 1'b1; pslverr = slv;
    step();
    idle_bus();
  endtask

  task automatic clear_flags();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    preset = 1'b1; paddr = '0; pwrite = 1'b0; psel = '0; penable = 1'b0; pwdata = '0;
    pready = 1'b0; pslverr = 1'b0; chk_en = 1'b1; err_clr = 1'b0; err_mask = 6'h3F;
    step(); step();
    preset = 1'b0;
    step();
    expect_snap("reset", 6'h00, 16'd0, 16'd0, 16'd0);
    check_snap();
    check("reset_irq",  64'(err_irq),  64'd0);
    check("reset_addr", 64'(err_addr), 64'd0);

    // Legal write (no waits) then read with three waits
    apb_xfer(16'h00F0, 1'b1, 4'b0001, 32'h0000_1234, 0, 1'b0);
    apb_xfer(16'h0020, 1'b0, 4'b0100, 32'h0, 3, 1'b0);
    expect_snap("legal", 6'h00, 16'd2, 16'd0, 16'd0);
    step();
    check_snap();
    check("legal_irq", 64'(err_irq), 64'd0);

    // PENABLE without a setup phase
    err_mask = 6'b000001;
    paddr = 16'h0040; pwrite = 1'b0; psel = 4'b0010; penable = 1'b1; pready = 1'b0;
    step();
    check("pen_flags_1cyc", 64'(err_flags), 64'h01);
    check("pen_irq_1cyc",   64'(err_irq),   64'd0);
    check("pen_addr",       64'(err_addr),  64'h40);
    pready = 1'b1;
    step();
    idle_bus();
    check("pen_irq_2cyc", 64'(err_irq), 64'd1);
    expect_snap("pen_no_setup", 6'b000001, 16'd3, 16'd1, 16'd0);
    check_snap();
    clear_flags();
    step();
    check("clr_flags", 64'(err_flags), 64'd0);
    check("clr_irq",   64'(err_irq),   64'd0);

    // Write data changes during the second wait state
    paddr = 16'h00F4; pwrite = 1'b1; psel = 4'b0001; pwdata = 32'hA5;
    penable = 1'b0; pready = 1'b0;
    step();
    penable = 1'b1;
    step();
    pwdata = 32'h5A;
    step();
    pwdata = 32'hA5; pready = 1'b1;
    step();
    idle_bus();
    expect_snap("unstable", 6'b000100, 16'd4, 16'd2, 16'd0);
    check_snap();
    check("unstable_addr", 64'(err_addr), 64'hF4);

    // Multi-select together with a clear of the existing unstable flag
    paddr = 16'h0050; pwrite = 1'b0; psel = 4'b0011; penable = 1'b0; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    expect_snap("multi_clr", 6'b001000, 16'd4, 16'd3, 16'd0);
    check_snap();
    check("multi_addr", 64'(err_addr), 64'h50);
    penable = 1'b1; pready = 1'b1;
    step();
    idle_bus();
    expect_snap("multi_done", 6'b001000, 16'd5, 16'd4, 16'd0);
    check_snap();
    clear_flags();

    // Hang: four waits allowed, the fifth pready=0 access cycle is a violation
    paddr = 16'h00F0; pwrite = 1'b1; psel = 4'b0001; pwdata = 32'h1;
    penable = 1'b0; pready = 1'b0;
    step();
    penable = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("hang_not_yet", 64'(err_flags), 64'd0);
    step();
    idle_bus();
    expect_snap("hang", 6'b010000, 16'd5, 16'd5, 16'd0);
    check_snap();
    step();
    apb_xfer(16'h0000, 1'b0, 4'b1000, 32'h0, 0, 1'b0);
    expect_snap("after_hang", 6'b010000, 16'd6, 16'd5, 16'd0);
    check_snap();
    clear_flags();

    // Write to an address outside the legal map
    apb_xfer(16'h0010, 1'b1, 4'b0001, 32'h7, 0, 1'b0);
    expect_snap("addr_map", (AMAP != 0) ? 6'b100000 : 6'b000000, 16'd7, 16'(5 + AMAP), 16'd0);
    check_snap();

    // Twenty slave-error completions
    for (int i = 0; i < 20; i++) apb_xfer(16'h0000, 1'b0, 4'b0100, 32'h0, 0, 1'b1);
    expect_snap("slverr", (AMAP != 0) ? 6'b100000 : 6'b000000, 16'd27, 16'(5 + AMAP), 16'd20);
    check_snap();
    check("small_slverr_sat", 64'(s_slverr_cnt), 64'hF);
    check("small_xfer_wrap",  64'(s_xfer_cnt),   64'd11);

    // Checking disabled: violation and completion leave state frozen
    chk_en = 1'b0;
    paddr = 16'h0060; pwrite = 1'b0; psel = 4'b0011; penable = 1'b0;
    step();
    penable = 1'b1; pready = 1'b1;
    step();
    idle_bus();
    chk_en = 1'b1;
    expect_snap("chk_off", (AMAP != 0) ? 6'b100000 : 6'b000000, 16'd27, 16'(5 + AMAP), 16'd20);
    check_snap();

    // Reset in the middle of ACCESS
    err_mask = 6'h3F;
    paddr = 16'h00F0; pwrite = 1'b1; psel = 4'b0001; pwdata = 32'h9;
    penable = 1'b0; pready = 1'b0;
    step();
    penable = 1'b1;
    step();
    preset = 1'b1;
    #1;
    expect_snap("mid_reset", 6'h00, 16'd0, 16'd0, 16'd0);
    check_snap();
    check("mid_reset_irq",  64'(err_irq),  64'd0);
    check("mid_reset_addr", 64'(err_addr), 64'd0);
    idle_bus();
    step();
    preset = 1'b0;
    step();
    apb_xfer(16'h00F4, 1'b1, 4'b0010, 32'h3, 1, 1'b0);
    expect_snap("post_reset", 6'h00, 16'd1, 16'd0, 16'd0);
    check_snap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
